mul_nbitxn_wallace_pipe: RTL and testbench
==========================================

Name: mul_nbitxn_wallace_pipe

Overview:
- Parametrised, 3-stage pipelined DATA_W x DATA_W multiplier producing a 2*DATA_W-bit product.
- Partial products are reduced by a Wallace tree of add_01bit_full 3:2 compressors to a carry-save pair, followed by a final carry-propagate add.
- Supports unsigned and signed (two's complement) operation per transaction.
- Sits in the calc/mul datapath; upstream and downstream connect through valid/ready handshakes.

Parameters:
- DATA_W, 32, operand width; legal range is even values 4..64.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_valid  input  1  operand pair valid
- o_ready  output  1  block can accept operands this cycle
- i_num_a  input  DATA_W  multiplicand
- i_num_b  input  DATA_W  multiplier
- i_signed  input  1  1 = both operands signed, 0 = both unsigned; sampled with operands
- o_valid  output  1  product valid
- i_ready  input  1  downstream accepts product
- o_res  output  2*DATA_W  product
- o_busy  output  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (i_rst_n low, asynchronous): all stage valid bits = 0; all data registers = 0; o_valid = 0; o_res = 0; o_busy = 0. o_ready = 1 once reset is released.
- Stages:
  - S1 registers operands and i_signed.
  - S2 builds the partial products and runs the Wallace reduction to two rows, registering the sum and carry rows (2*DATA_W bits each).
  - S3 adds the two rows and registers o_res.
- Stall and advance:
  - stall = v3 & ~i_ready; o_ready = ~stall (combinational).
  - When stall = 0, every stage advances simultaneously: v1 <= i_valid, v2 <= v1, v3 <= v2, with data following.
  - When stall = 1, all stages hold; no data register changes.
  - Bubbles are not collapsed.
- Accept occurs when i_valid & o_ready. Latency is exactly 3 cycles from accept to o_valid with no stall. Throughput is 1 product per cycle.
- o_valid = v3. o_res holds stable while o_valid & ~i_ready.
- Signed mode: each operand is extended by one bit (sign bit if i_signed, else 0) to DATA_W+1 bits. The product is the low 2*DATA_W bits of the (DATA_W+1)x(DATA_W+1) product; the extension bit's partial product row is subtracted (Baugh-Wooley form).
- Arithmetic:
  - o_res is exact for all inputs: no overflow is possible in 2*DATA_W bits.
  - Carry-out of the final adder is discarded.
  - Internal column heights are reduced in 3:2 layers until height <= 2.
- The i_signed value is carried with each transaction, so signed and unsigned operations may alternate back to back.
- o_busy = v1 | v2 | v3.
- Reset mid-operation: all in-flight transactions are lost, and no o_valid pulse is produced for them after release.
- Operand and mode inputs are don't-care when i_valid = 0.

Optional Feature:
- Macro MUL_WALLACE_FLUSH_EN.
- When defined:
  - Adds port i_flush (input, 1 bit).
  - i_flush high at a rising edge clears v1, v2 and v3 to 0 regardless of stall. Data registers are untouched.
  - An operand presented in the same cycle is dropped, and o_ready is forced to 0 while i_flush = 1.
  - Flush takes priority over accept and stall.
- When undefined: no i_flush port and no flush logic; behaviour is as above.

Test Plan:
- DATA_W=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> o_valid exactly 3 cycles after accept, o_res=0xFFFFFFFE00000001.
- Signed back-to-back (no stall): (-3)x5, then 0x80000000x0x80000000, then (-1)x(-1) -> on consecutive cycles o_res = 0xFFFFFFFFFFFFFFF1, then 0x4000000000000000, then 0x0000000000000001.
- Mixed mode on the same operands: a=0xFFFFFFFF, b=0x00000002 with i_signed=1 then i_signed=0 -> 0xFFFFFFFFFFFFFFFE, then 0x00000001FFFFFFFE.
- Backpressure: stream 4 operations with i_ready held 0 from cycle 3 for 5 cycles -> o_ready=0 during the stall, o_res holds its first value, no loss or duplication; all 4 products delivered in order after i_ready=1.
- Reset mid-flight: accept 2 ops, assert i_rst_n=0 asynchronously between edges -> o_valid, o_busy, o_res go to 0 immediately; no outputs after release.
- With MUL_WALLACE_FLUSH_EN: 3 ops in flight, pulse i_flush for one cycle -> o_busy=0 next cycle, no o_valid; the next op after flush returns the correct product with 3-cycle latency.

Source files
------------

// File: rtl/mul_nbitxn_wallace_pipe.sv
// Three-stage DATA_W x DATA_W multiplier: operand register, Wallace carry-save reduction, final add.
// Optional pipeline flush input is enabled with `define MUL_WALLACE_FLUSH_EN.
module mul_nbitxn_wallace_pipe #(
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_W-1:0]     i_num_a,
    input  logic [DATA_W-1:0]     i_num_b,
    input  logic                  i_signed,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*DATA_W-1:0]   o_res,
    output logic                  o_busy
`ifdef MUL_WALLACE_FLUSH_EN
    ,
    input  logic                  i_flush
`endif
);

    localparam int W  = 2 * DATA_W;
    // DATA_W operand-bit rows, the negated extension row and its +1 correction row
    localparam int NR = DATA_W + 2;

    function automatic logic [1:0] add_01bit_full(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // one 3:2 layer across a whole row; returns {carry row already weighted by 2, sum row}
    function automatic logic [2*W-1:0] csa_row(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [W-1:0] z);
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [1:0]   fa;
        for (int k = 0; k < W; k++) begin
            fa   = add_01bit_full(x[k], y[k], z[k]);
            s[k] = fa[0];
            c[k] = fa[1];
        end
        return {c << 1, s};
    endfunction

    function automatic int rows_next(input int n);
        return (n > 2) ? ((n / 3) * 2 + (n % 3)) : n;
    endfunction

    function automatic int layers_needed(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int k = 0; k < 64; k++) begin
            if (c > 2) begin
                c = rows_next(c);
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int NL = layers_needed(NR);

    logic                v1_r, v2_r, v3_r;
    logic [DATA_W-1:0]   a1_r, b1_r;
    logic                sgn1_r;
    logic [W-1:0]        sum2_r, carry2_r;
    logic [W-1:0]        res_r;
    logic                stall_s;
    logic                a_ext_s, b_ext_s;
    logic [W-1:0]        ax_s;
    logic [W-1:0]        pp_s  [0:NR-1];
    logic [W-1:0]        lay_s [0:NL][0:NR+1];

    assign stall_s = v3_r & ~i_ready;
`ifdef MUL_WALLACE_FLUSH_EN
    assign o_ready = ~stall_s & ~i_flush;
`else
    assign o_ready = ~stall_s;
`endif
    assign o_valid = v3_r;
    assign o_res   = res_r;
    assign o_busy  = v1_r | v2_r | v3_r;

    // partial-product rows; the extension bit of b carries negative weight so its row is negated
    always_comb begin
        a_ext_s = sgn1_r & a1_r[DATA_W-1];
        b_ext_s = sgn1_r & b1_r[DATA_W-1];
        ax_s    = {{DATA_W{a_ext_s}}, a1_r};
        for (int j = 0; j < DATA_W; j++) begin
            pp_s[j] = b1_r[j] ? (ax_s << j) : {W{1'b0}};
        end
        pp_s[DATA_W]   = b_ext_s ? ~(ax_s << DATA_W) : {W{1'b0}};
        pp_s[DATA_W+1] = {{(W-1){1'b0}}, b_ext_s};
    end

    // Wallace reduction: each layer compresses row triples, leftover rows pass straight down
    always_comb begin : wallace_reduce
        int n_rows;
        int n_grp;
        n_rows = NR;
        n_grp  = 0;
        for (int l = 0; l <= NL; l++) begin
            for (int r = 0; r < NR + 2; r++) begin
                lay_s[l][r] = {W{1'b0}};
            end
        end
        for (int r = 0; r < NR; r++) begin
            lay_s[0][r] = pp_s[r];
        end
        for (int l = 0; l < NL; l++) begin
            n_grp = n_rows / 3;
            for (int g = 0; g < NR / 3; g++) begin
                if (g < n_grp) begin
                    {lay_s[l+1][2*g+1], lay_s[l+1][2*g]} =
                        csa_row(lay_s[l][3*g], lay_s[l][3*g+1], lay_s[l][3*g+2]);
                end else begin
                    lay_s[l+1][2*g]   = {W{1'b0}};
                    lay_s[l+1][2*g+1] = {W{1'b0}};
                end
            end
            for (int p = 0; p < 2; p++) begin
                lay_s[l+1][2*n_grp+p] = (3*n_grp + p < n_rows) ? lay_s[l][3*n_grp+p] : {W{1'b0}};
            end
            n_rows = rows_next(n_rows);
        end
    end

    // stage valid bits: flush clears, otherwise all stages advance together unless stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end
`ifdef MUL_WALLACE_FLUSH_EN
        else if (i_flush) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end
`endif
        else if (!stall_s) begin
            v1_r <= i_valid;
            v2_r <= v1_r;
            v3_r <= v2_r;
        end
    end

    // stage data registers, frozen while the output is stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a1_r     <= {DATA_W{1'b0}};
            b1_r     <= {DATA_W{1'b0}};
            sgn1_r   <= 1'b0;
            sum2_r   <= {W{1'b0}};
            carry2_r <= {W{1'b0}};
            res_r    <= {W{1'b0}};
        end else if (!stall_s) begin
            a1_r     <= i_num_a;
            b1_r     <= i_num_b;
            sgn1_r   <= i_signed;
            sum2_r   <= lay_s[NL][0];
            carry2_r <= lay_s[NL][1];
            res_r    <= sum2_r + carry2_r;
        end
    end

endmodule

// File: tb/tb_mul_nbitxn_wallace_pipe.sv
// Scoreboard bench for mul_nbitxn_wallace_pipe (DATA_W=32); flush scenario under MUL_WALLACE_FLUSH_EN.
module tb_mul_nbitxn_wallace_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        o_ready, o_valid, o_busy;
    logic [63:0] o_res;
`ifdef MUL_WALLACE_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    logic [63:0] sb_q [$];
    logic [63:0] exp_m;

    mul_nbitxn_wallace_pipe #(.DATA_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_num_a (a),
        .i_num_b (b),
        .i_signed(i_signed),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_busy  (o_busy)
`ifdef MUL_WALLACE_FLUSH_EN
        ,.i_flush(flush)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] xa, input logic [31:0] xb, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{xa[31]}}, xa} : {32'h0, xa};
        eb = s ? {{32{xb[31]}}, xb} : {32'h0, xb};
        return ea * eb;
    endfunction

    // scoreboard: push on accept, pop and compare on delivery, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (o_valid && i_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, queue empty", o_res);
                end else begin
                    exp_m = sb_q.pop_front();
                    n_pop++;
                    if (o_res !== exp_m) begin
                        n_fail++;
                        $display("FAIL sb_product: got %h, expected %h", o_res, exp_m);
                    end
                end
            end
            if (i_valid && o_ready) sb_q.push_back(model(a, b, i_signed));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] xa, input logic [31:0] xb, input logic s);
        i_valid  = v;
        a        = xa;
        b        = xb;
        i_signed = s;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_res !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b res=%h, expected 0/0/0", o_valid, o_busy, o_res);
        end
        #10 rst_n = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", o_ready);
        end
        cyc();
    endtask

    task automatic test_unsigned_max();
        int lat;
        i_ready = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        lat = 1;
        while (!o_valid && lat < 10) begin
            cyc();
            lat++;
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL umax_latency: got %0d cycles, expected 3", lat);
        end
        n_tests++;
        if (o_res !== 64'hFFFFFFFE00000001) begin
            n_fail++;
            $display("FAIL umax_value: got %h, expected fffffffe00000001", o_res);
        end
        cyc();
        cyc();
    endtask

    task automatic test_signed_b2b();
        logic [63:0] exp_c [3];
        int k;
        exp_c[0] = 64'hFFFFFFFFFFFFFFF1;
        exp_c[1] = 64'h4000000000000000;
        exp_c[2] = 64'h0000000000000001;
        drive(1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b1);
        cyc();
        drive(1'b1, 32'h80000000, 32'h80000000, 1'b1);
        cyc();
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        k = 0;
        while (!o_valid && k < 10) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_res !== exp_c[i]) begin
                n_fail++;
                $display("FAIL signed_b2b[%0d]: valid=%b res=%h, expected 1/%h", i, o_valid, o_res, exp_c[i]);
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_mixed_mode();
        logic [63:0] exp_c [2];
        int k;
        exp_c[0] = 64'hFFFFFFFFFFFFFFFE;
        exp_c[1] = 64'h00000001FFFFFFFE;
        drive(1'b1, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        cyc();
        drive(1'b1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        k = 0;
        while (!o_valid && k < 10) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_res !== exp_c[i]) begin
                n_fail++;
                $display("FAIL mixed_mode[%0d]: valid=%b res=%h, expected 1/%h", i, o_valid, o_res, exp_c[i]);
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [31:0] op_a [4];
        logic [31:0] op_b [4];
        logic        op_s [4];
        logic [63:0] first_exp;
        int          sent;
        int          pop0;
        op_a[0] = 32'h12345678; op_b[0] = 32'h9ABCDEF0; op_s[0] = 1'b0;
        op_a[1] = 32'hFFFFFFFF; op_b[1] = 32'h00000007; op_s[1] = 1'b1;
        op_a[2] = 32'h80000000; op_b[2] = 32'hFFFFFFFF; op_s[2] = 1'b1;
        op_a[3] = 32'h0000FFFF; op_b[3] = 32'h00010001; op_s[3] = 1'b0;
        first_exp = model(op_a[0], op_b[0], op_s[0]);
        sent = 0;
        pop0 = n_pop;
        for (int c = 0; c < 20; c++) begin
            i_ready = !(c >= 3 && c < 8);
            if (sent < 4) drive(1'b1, op_a[sent], op_b[sent], op_s[sent]);
            else drive(1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            if (c >= 3 && c < 8) begin
                n_tests++;
                if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_res !== first_exp) begin
                    n_fail++;
                    $display("FAIL bp_hold[c=%0d]: ready=%b valid=%b res=%h, expected 0/1/%h",
                             c, o_ready, o_valid, o_res, first_exp);
                end
            end
            if (i_valid && o_ready) sent++;
            cyc();
        end
        i_ready = 1'b1;
        n_tests++;
        if (n_pop - pop0 != 4 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: delivered %0d pending %0d, expected 4/0", n_pop - pop0, sb_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        i_ready = 1'b1;
        drive(1'b1, 32'h0000BEEF, 32'h00001234, 1'b0);
        cyc();
        drive(1'b1, 32'h0000CAFE, 32'h00005678, 1'b0);
        cyc();
        drive(1'b0, 32'h0000CAFE, 32'h00005678, 1'b0);
        cyc();
        n_tests++;
        if (o_valid !== 1'b1 || o_res !== 64'h0000BEEF * 64'h00001234) begin
            n_fail++;
            $display("FAIL rst_pre: valid=%b res=%h, expected 1/%h", o_valid, o_res, 64'h0000BEEF * 64'h00001234);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_res !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b busy=%b res=%h, expected 0/0/0", o_valid, o_busy, o_res);
        end
        cyc();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (o_valid || o_busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_output: %0d active cycles after release, expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4];
        int          k;
        corner[0] = 32'h00000000;
        corner[1] = 32'h80000000;
        corner[2] = 32'h7FFFFFFF;
        corner[3] = 32'hFFFFFFFF;
        for (int c = 0; c < 80; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0)
                drive(1'b1, corner[$urandom_range(0, 3)], corner[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
            else
                drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        i_ready = 1'b1;
        k = 0;
        while (o_busy && k < 30) begin
            cyc();
            k++;
        end
        cyc();
        n_tests++;
        if (o_busy !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: busy=%b pending=%0d, expected 0/0", o_busy, sb_q.size());
        end
    endtask

`ifdef MUL_WALLACE_FLUSH_EN
    task automatic test_flush();
        int lat;
        i_ready = 1'b0;
        drive(1'b1, 32'h00000011, 32'h00000022, 1'b0);
        cyc();
        drive(1'b1, 32'h00000033, 32'h00000044, 1'b0);
        cyc();
        drive(1'b1, 32'h00000055, 32'h00000066, 1'b0);
        cyc();
        drive(1'b1, 32'h00000077, 32'h00000088, 1'b0);
        flush = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b, expected 0", o_ready);
        end
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: busy=%b valid=%b, expected 0/0", o_busy, o_valid);
        end
        sb_q.delete();
        i_ready = 1'b1;
        drive(1'b1, 32'd1234, 32'd5678, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        lat = 1;
        while (!o_valid && lat < 10) begin
            cyc();
            lat++;
        end
        n_tests++;
        if (lat != 3 || o_res !== 64'd7006652) begin
            n_fail++;
            $display("FAIL flush_next: latency %0d res=%h, expected 3/%h", lat, o_res, 64'd7006652);
        end
        cyc();
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_b2b();
        test_mixed_mode();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef MUL_WALLACE_FLUSH_EN
        test_flush();
`endif
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d products never delivered", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
